// File: rtl/mul_share_ctrl.sv
// Round-robin scheduler that shares one repeated-addition multiplier datapath between two requesters.
// Optional macro MUL_ZERO_SKIP_EN bypasses the datapath when either granted operand is zero.
module mul_share_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic [WIDTH-1:0] dp_data,
   output logic             LdA,
   output logic             LdB,
   output logic             LdP,
   output logic             clrP,
   output logic             decB,
   input  logic             eqz,
   input  logic [WIDTH-1:0] dp_y
);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_grant;
   logic             r_ptr;
   logic [WIDTH-1:0] r_result;
   logic             w_anyReq;
   logic             w_grantSel;

   // The pointer only breaks ties; a lone requester is always granted.
   assign w_anyReq   = req0 | req1;
   assign w_grantSel = (req0 & req1) ? r_ptr : req1;

`ifdef MUL_ZERO_SKIP_EN
   logic w_zeroOp;
   assign w_zeroOp = w_grantSel ? ((a1 == '0) || (b1 == '0))
                                : ((a0 == '0) || (b0 == '0));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_grant  <= 1'b0;
         r_ptr    <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_anyReq)
            r_grant <= w_grantSel;
         if (r_state == DONE)
            r_ptr <= ~r_grant;
         if (r_state == ADD && eqz)
            r_result <= dp_y;
`ifdef MUL_ZERO_SKIP_EN
         if (r_state == IDLE && w_anyReq && w_zeroOp)
            r_result <= '0;
`endif
      end
   end

   always_comb begin
      w_next  = r_state;
      dp_data = '0;
      LdA     = 1'b0;
      LdB     = 1'b0;
      LdP     = 1'b0;
      clrP    = 1'b0;
      decB    = 1'b0;
      done0   = 1'b0;
      done1   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
`ifdef MUL_ZERO_SKIP_EN
               w_next = w_zeroOp ? DONE : LOAD_A;
`else
               w_next = LOAD_A;
`endif
            end
         end
         LOAD_A: begin
            dp_data = r_grant ? a1 : a0;
            LdA     = 1'b1;
            w_next  = LOAD_B;
         end
         LOAD_B: begin
            dp_data = r_grant ? b1 : b0;
            LdB     = 1'b1;
            clrP    = 1'b1;
            w_next  = ADD;
         end
         ADD: begin
            // One accumulate per remaining count; eqz ends the loop.
            if (!eqz) begin
               LdP  = 1'b1;
               decB = 1'b1;
            end else begin
               w_next = DONE;
            end
         end
         DONE: begin
            done0  = ~r_grant;
            done1  = r_grant;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign busy   = (r_state != IDLE);
   assign result = r_result;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural repeated-addition datapath attached.
// Expected results assume MUL_ZERO_SKIP_EN is undefined unless the bench is built with it.
module tb_mul_share_ctrl;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0 = 1'b0, req1 = 1'b0;
   logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic             done0, done1, busy;
   logic [WIDTH-1:0] result, dp_data;
   logic             LdA, LdB, LdP, clrP, decB, eqz;
   logic [WIDTH-1:0] dp_y;

   logic [WIDTH-1:0] dpA, dpB, dpP;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   int               cyc, ldpCnt, busyLow, ldaCyc, ldbCyc;
   logic [WIDTH-1:0] ldaData, ldbData;
   logic             got0, got1;
   int               doneSeen;

   always #5 clk = ~clk;

   mul_share_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .done0(done0), .done1(done1), .result(result), .busy(busy),
      .dp_data(dp_data), .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
      .eqz(eqz), .dp_y(dp_y)
   );

   // Behavioural stand-in for the shared 16-bit repeated-addition unit.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dpA <= '0;
         dpB <= '0;
         dpP <= '0;
      end else begin
         if (LdA) dpA <= dp_data;
         if (LdB) dpB <= dp_data;
         else if (decB) dpB <= dpB - 1'b1;
         if (clrP) dpP <= '0;
         else if (LdP) dpP <= dpP + dpA;
      end
   end
   assign eqz  = (dpB == '0);
   assign dp_y = dpP;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic [WIDTH-1:0] av0, input logic [WIDTH-1:0] bv0,
                                input logic r1, input logic [WIDTH-1:0] av1, input logic [WIDTH-1:0] bv1);
      @(negedge clk);
      req0 = r0; a0 = av0; b0 = bv0;
      req1 = r1; a1 = av1; b1 = bv1;
   endtask

   // Steps negedge by negedge until a done pulse; cycle 1 is the first cycle after the sampling edge.
   task automatic waitDone(input int limit, input int raiseCycle);
      cyc = 0; ldpCnt = 0; busyLow = 0; ldaCyc = 0; ldbCyc = 0;
      ldaData = '0; ldbData = '0; got0 = 1'b0; got1 = 1'b0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         cyc = i;
         if (LdA) begin ldaCyc = i; ldaData = dp_data; end
         if (LdB && clrP) begin ldbCyc = i; ldbData = dp_data; end
         if (LdP && decB) ldpCnt++;
         if (!busy) busyLow++;
         if (done0 || done1) begin
            got0 = done0;
            got1 = done1;
            break;
         end
         if (i == raiseCycle) req1 = 1'b1;
      end
      if (!(got0 || got1)) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      // Reset state
      #12;
      checkOutput("rst_ctrl", {24'd0, LdA, LdB, LdP, clrP, decB, done0, done1, busy}, 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_dp_data", dp_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Simultaneous pair right after reset: requester 0 first, then 1 after one idle cycle
      applyStimulus(1'b1, 16'd2, 16'd5, 1'b1, 16'd7, 16'd2);
      waitDone(40, 0);
      checkOutput("pair_first_done0", got0, 32'd1);
      checkOutput("pair_first_no_done1", got1, 32'd0);
      checkOutput("pair_first_cycle", cyc, 32'd9);
      checkOutput("pair_first_result", result, 32'd10);
      req0 = 1'b0;
      @(negedge clk);
      checkOutput("pair_gap_busy", busy, 32'd0);
      waitDone(40, 0);
      checkOutput("pair_second_done1", got1, 32'd1);
      checkOutput("pair_second_cycle", cyc, 32'd6);
      checkOutput("pair_second_result", result, 32'd14);
      req1 = 1'b0;

      // Single job 4 x 3 on requester 0
      applyStimulus(1'b1, 16'd4, 16'd3, 1'b0, 16'd0, 16'd0);
      waitDone(40, 0);
      checkOutput("single_lda_cycle", ldaCyc, 32'd1);
      checkOutput("single_lda_data", ldaData, 32'd4);
      checkOutput("single_ldb_cycle", ldbCyc, 32'd2);
      checkOutput("single_ldb_data", ldbData, 32'd3);
      checkOutput("single_add_count", ldpCnt, 32'd3);
      checkOutput("single_done_cycle", cyc, 32'd7);
      checkOutput("single_done0", got0, 32'd1);
      checkOutput("single_no_done1", got1, 32'd0);
      checkOutput("single_result", result, 32'd12);
      req0 = 1'b0;
      @(negedge clk);
      checkOutput("single_idle_busy", busy, 32'd0);

      // Pointer now favours requester 1 for a simultaneous pair
      applyStimulus(1'b1, 16'd2, 16'd5, 1'b1, 16'd7, 16'd2);
      waitDone(40, 0);
      checkOutput("rr_done1_first", got1, 32'd1);
      checkOutput("rr_no_done0", got0, 32'd0);
      checkOutput("rr_result", result, 32'd14);
      req0 = 1'b0; req1 = 1'b0;

      // Zero multiplier on requester 1
      applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 16'd9, 16'd0);
      waitDone(40, 0);
      checkOutput("zero_add_count", ldpCnt, 32'd0);
`ifdef MUL_ZERO_SKIP_EN
      checkOutput("zero_done_cycle", cyc, 32'd1);
`else
      checkOutput("zero_done_cycle", cyc, 32'd4);
`endif
      checkOutput("zero_done1", got1, 32'd1);
      checkOutput("zero_result", result, 32'd0);
      req1 = 1'b0;

      // Truncated product
      applyStimulus(1'b1, 16'hFFFF, 16'd2, 1'b0, 16'd0, 16'd0);
      waitDone(40, 0);
      checkOutput("trunc_done_cycle", cyc, 32'd6);
      checkOutput("trunc_result", result, 32'hFFFE);
      req0 = 1'b0;

      // Asynchronous reset during ADD of a 5 x 6 job
      applyStimulus(1'b1, 16'd5, 16'd6, 1'b0, 16'd0, 16'd0);
      repeat (4) @(negedge clk);
      checkOutput("abort_pre_ldp", LdP, 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_ctrl", {24'd0, LdA, LdB, LdP, clrP, decB, done0, done1, busy}, 32'd0);
      checkOutput("abort_result", result, 32'd0);
      checkOutput("abort_dp_data", dp_data, 32'd0);
      req0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done0 || done1) doneSeen++;
      end
      checkOutput("abort_no_done", doneSeen, 32'd0);
      applyStimulus(1'b1, 16'd3, 16'd3, 1'b1, 16'd2, 16'd2);
      waitDone(40, 0);
      checkOutput("post_rst_ptr_done0", got0, 32'd1);
      checkOutput("post_rst_cycle", cyc, 32'd7);
      checkOutput("post_rst_result", result, 32'd9);
      req0 = 1'b0; req1 = 1'b0;

      // Requester 1 arrives while requester 0 is in ADD
      applyStimulus(1'b1, 16'd4, 16'd3, 1'b0, 16'd5, 16'd4);
      waitDone(40, 4);
      checkOutput("late_done0", got0, 32'd1);
      checkOutput("late_no_done1", got1, 32'd0);
      checkOutput("late_done0_cycle", cyc, 32'd7);
      checkOutput("late_busy_held", busyLow, 32'd0);
      checkOutput("late_result0", result, 32'd12);
      req0 = 1'b0;
      @(negedge clk);
      checkOutput("late_gap_busy", busy, 32'd0);
      waitDone(40, 0);
      checkOutput("late_lda_data", ldaData, 32'd5);
      checkOutput("late_done1", got1, 32'd1);
      checkOutput("late_done1_cycle", cyc, 32'd8);
      checkOutput("late_busy_low", busyLow, 32'd0);
      checkOutput("late_result1", result, 32'd20);
      req1 = 1'b0;

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Scheduler/controller that shares one repeated-addition multiplier datapath between two requesters.
- The datapath is the existing 16-bit unit with control inputs LdA, LdB, LdP, clrP, decB, a data_in bus, an eqz flag and product output Y.
- This block arbitrates the requesters round-robin and sequences the datapath's control strobes.
- It registers the product and returns a one-cycle done pulse to the served requester.

Parameters:
- WIDTH, 16, width of operands, the datapath bus and the product.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req0  input  1  requester 0 request; held high with a0/b0 stable until done0
- a0  input  WIDTH  requester 0 multiplicand
- b0  input  WIDTH  requester 0 multiplier (repeat count)
- req1  input  1  requester 1 request
- a1  input  WIDTH  requester 1 multiplicand
- b1  input  WIDTH  requester 1 multiplier
- done0  output  1  one-cycle pulse, result valid for requester 0
- done1  output  1  one-cycle pulse, result valid for requester 1
- result  output  WIDTH  registered product, held until the next capture
- busy  output  1  high in any state other than IDLE
- dp_data  output  WIDTH  drives datapath data_in
- LdA, LdB, LdP, clrP, decB  output  1 each  datapath control strobes
- eqz  input  1  datapath flag: B register == 0 (combinational from B)
- dp_y  input  WIDTH  datapath product Y

Behaviour:
- Reset (async, any state, mid-operation included):
  - state = IDLE; all strobes, done0/1, busy = 0; result = 0; dp_data = 0.
  - Priority pointer = 0 (requester 0 preferred).
  - An aborted operation produces no done pulse.
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE.
- IDLE: busy = 0.
  - Any req high at the clock edge -> grant g is latched -> LOAD_A.
  - Both high -> grant goes to the pointer's requester.
  - Only one high -> grant goes to that requester.
- LOAD_A: dp_data = a_g, LdA = 1 -> LOAD_B.
- LOAD_B: dp_data = b_g, LdB = 1, clrP = 1 -> ADD.
- ADD:
  - eqz = 0 -> LdP = 1, decB = 1, stay in ADD.
  - eqz = 1 -> no strobes; result <= dp_y; -> DONE.
- DONE: done_g = 1 for exactly one cycle; pointer <= ~g -> IDLE.
- dp_data = 0 in every state except LOAD_A and LOAD_B.
- Strobes are combinational from state and eqz; they are never asserted outside the states listed above.
- Latency, counted from the edge that samples req in IDLE: done asserted B+4 cycles later (B = multiplier value). ADD strobes are issued for exactly B cycles.
- Arithmetic: the product is the datapath's WIDTH-bit sum, truncated modulo 2^WIDTH. No overflow flag.
- Requests arriving while busy wait; the other requester is served on return to IDLE if its req is still high.
- req dropped mid-operation: the operation completes, done still pulses, and the pointer still updates.
- req still high in the IDLE cycle after done is treated as a new request. Requesters must drop req on done.
- B = 0: ADD is entered with eqz = 1, so no LdP/decB is issued and result = 0; done at cycle 4.
- Back-to-back: fixed one IDLE cycle between DONE and the next LOAD_A.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined:
  - In IDLE, if the granted requester's a_g == 0 or b_g == 0, the datapath is bypassed and no strobes are issued.
  - result <= 0 and the next state is DONE, so done pulses 1 cycle after the sampling edge.
  - Pointer update is unchanged.
- Undefined: zero operands take the normal datapath path; latency is B+4.

Test Plan:
- req0, a0 = 4, b0 = 3, req1 = 0 -> LdA then LdB/clrP, 3 cycles of LdP/decB, done0 7 cycles after sampling, result = 12, done1 never asserted.
- req0 and req1 asserted in the same cycle after reset; a0 = 2, b0 = 5; a1 = 7, b1 = 2 -> req0 served first (result = 10, done0); then req1 (result = 14, done1). Next simultaneous pair serves requester 1 first.
- a1 = 9, b1 = 0 -> zero LdP/decB strobes, result = 0, done1 at cycle 4 (cycle 1 with MUL_ZERO_SKIP_EN).
- a0 = 16'hFFFF, b0 = 2 -> result = 16'hFFFE (truncated), done0 at cycle 6.
- rst pulsed during ADD of a 5x6 job -> all outputs 0 immediately, no done0. After release, a new 3x3 request -> result = 9 and the pointer is back at 0.
- req1 raised while the req0 job is in ADD -> req1 not granted until after done0, then served with one IDLE cycle gap; busy low only in that IDLE cycle.
